// File: rtl/peak_capture_ctrl_pkg.sv
// peak_capture_ctrl_pkg: shared states, record layout and default constants for the peak capture controller.
package peak_capture_ctrl_pkg;
    localparam int DATA_W_DEF  = 8;
    localparam int TS_W_DEF    = 10;
    localparam int WINDOW_DEF  = 512;
    localparam int DET_LAT_DEF = 3;

    typedef enum logic [1:0] {IDLE, CLEAR, ACQUIRE, DRAIN} state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] amp;
        logic [TS_W_DEF-1:0]   stamp;
    } record_t;
endpackage

// File: rtl/peak_capture_ctrl_fifo.sv
// peak_rec_fifo: single-clock FIFO with extra-MSB binary pointers; clr empties it in one edge.
module peak_rec_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr, rdPtr;

    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign empty = wrPtr == rdPtr;
    assign dout  = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (clr) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push && !full) wrPtr <= wrPtr + 1'b1;
            if (pop && !empty) rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (push && !full && !clr) mem[wrPtr[AW-1:0]] <= din;
endmodule

// File: rtl/peak_capture_ctrl.sv
// peak_capture_ctrl: runs one acquisition window of the peak detector, timestamps peaks and drains them over valid/ready.
module peak_capture_ctrl
    import peak_capture_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TS_W    = TS_W_DEF,
    parameter int WINDOW  = WINDOW_DEF,
    parameter int DEPTH   = 8,
    parameter int DET_LAT = DET_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] min_level_in,
    input  logic              pk_detected,
    input  logic [DATA_W-1:0] pk_amp,
    output logic              det_rst,
    output logic              det_enable,
    output logic [DATA_W-1:0] det_min_level,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [DATA_W-1:0] rec_amp,
    output logic [TS_W-1:0]   rec_time,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [TS_W:0]     pk_count
);
    state_t                   state, nextState;
    logic [TS_W-1:0]          cnt, ts;
    logic [TS_W:0]            tsDiff;
    logic                     abortRst, accStart, doAbort, lastSample;
    logic                     push, pop, full, empty;
    logic [DATA_W+TS_W-1:0]   head;

    assign accStart   = state == IDLE && start;
    assign doAbort    = state != IDLE && abort;
    assign lastSample = cnt == TS_W'(WINDOW - 1);
    // Undo detector latency; peaks flagged before DET_LAT samples clamp to 0.
    assign tsDiff     = {1'b0, cnt} - (TS_W+1)'(DET_LAT);
    assign ts         = tsDiff[TS_W] ? '0 : tsDiff[TS_W-1:0];
    assign push       = state == ACQUIRE && pk_detected && !full;
    assign pop        = rec_valid && rec_ready;
    assign busy       = state != IDLE;
    assign rec_amp    = rec_valid ? head[DATA_W+TS_W-1:TS_W] : '0;
    assign rec_time   = rec_valid ? head[TS_W-1:0] : '0;

    always_comb begin
        nextState  = state;
        det_rst    = abortRst;
        det_enable = 1'b0;
        rec_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:    nextState = start ? CLEAR : IDLE;
            CLEAR: begin
                det_rst   = 1'b1;
                nextState = ACQUIRE;
            end
            ACQUIRE: begin
                det_enable = 1'b1;
                nextState  = lastSample ? DRAIN : ACQUIRE;
            end
            DRAIN: begin
                rec_valid = !empty;
                done      = empty && !abort;
                nextState = empty ? IDLE : DRAIN;
            end
            default: nextState = IDLE;
        endcase
        if (doAbort) nextState = IDLE;
    end

    // abortRst resets to 1 so det_rst is high while reset holds and for the first cycle after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            abortRst      <= 1'b1;
            det_min_level <= '0;
            overflow      <= 1'b0;
            pk_count      <= '0;
        end else begin
            state    <= nextState;
            abortRst <= doAbort;
            cnt      <= state == ACQUIRE ? cnt + 1'b1 : '0;
            if (accStart) begin
                det_min_level <= min_level_in;
                overflow      <= 1'b0;
                pk_count      <= '0;
            end else if (state == ACQUIRE && pk_detected) begin
                if (pk_count != '1) pk_count <= pk_count + 1'b1;
                if (full) overflow <= 1'b1;
            end
        end
    end

    peak_rec_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W + TS_W)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .clr  (accStart || doAbort),
        .push (push),
        .pop  (pop),
        .din  ({pk_amp, ts}),
        .dout (head),
        .full (full),
        .empty(empty)
    );
endmodule

// File: doc/peak_capture_ctrl.md
Name: peak_capture_ctrl

Overview:
- Sequences one acquisition window of the peak detector: resets it with a latched minimum level, enables it for a fixed number of samples, and timestamps every detected peak.
- Buffers the peak records in a small FIFO and drains them to the readout path (UART/host formatter) over a valid/ready handshake.
- Sits between the host command decoder and the peak detector datapath.

Parameters:
- DATA_W, 8, width of sample, amplitude and min level.
- TS_W, 10, timestamp width (sample index within window).
- WINDOW, 512, samples per acquisition; must satisfy 2 <= WINDOW <= 2^TS_W.
- DEPTH, 8, FIFO entries; power of two.
- DET_LAT, 3, detector latency from sample entry to pk_detected; subtracted from timestamps.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin an acquisition.
- abort  in  1  single-cycle request to cancel the current operation.
- min_level_in  in  DATA_W  threshold floor; latched on an accepted start.
- pk_detected  in  1  peak flag from the detector.
- pk_amp  in  DATA_W  peak amplitude from the detector.
- det_rst  out  1  detector reset (reloads its threshold).
- det_enable  out  1  detector shift enable.
- det_min_level  out  DATA_W  latched min level driven to the detector.
- rec_valid  out  1  FIFO head valid.
- rec_ready  in  1  readout accepts the head record.
- rec_amp  out  DATA_W  head record amplitude.
- rec_time  out  TS_W  head record timestamp.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a drain completes.
- overflow  out  1  sticky flag: a peak was dropped because the FIFO was full.
- pk_count  out  TS_W+1  peaks detected in the last or current window, including dropped peaks.

Behaviour:
- Reset (asynchronous) values:
  - state = IDLE; all outputs 0, except det_rst = 1.
  - FIFO empty, counters 0, det_min_level = 0.
- States: IDLE, CLEAR, ACQUIRE, DRAIN.
- IDLE:
  - det_enable = 0, det_rst = 0.
  - On start: latch min_level_in into det_min_level, clear FIFO, overflow and pk_count, then go to CLEAR.
  - start is ignored in every other state.
- CLEAR: exactly 1 cycle with det_rst = 1, then go to ACQUIRE with sample counter = 0.
- ACQUIRE:
  - det_enable = 1 for exactly WINDOW cycles; counter runs 0..WINDOW-1.
  - Each cycle with pk_detected = 1:
    - pk_count increments, saturating at all-ones.
    - If the FIFO is not full, push {pk_amp, ts} with ts = counter - DET_LAT, saturating at 0.
    - If the FIFO is full, drop the record and set overflow.
  - pk_detected is ignored outside ACQUIRE.
  - On counter = WINDOW-1: a push in that cycle is still taken; go to DRAIN next cycle with det_enable = 0.
- DRAIN:
  - rec_valid = !empty; rec_amp/rec_time show the FIFO head, registered from FIFO storage.
  - Pop on rec_valid && rec_ready.
  - rec_amp and rec_time must hold stable while rec_valid = 1 and rec_ready = 0.
  - When the FIFO is empty, including when entered empty: pulse done for 1 cycle and go to IDLE.
  - done and the return to IDLE occur in the cycle after the last pop.
- abort, in any non-IDLE state, on the next edge:
  - go to IDLE; det_enable = 0; det_rst pulsed 1 cycle; FIFO cleared; rec_valid = 0; no done pulse.
  - overflow and pk_count keep their values.
- abort and start in the same cycle while in IDLE: start wins; abort is a no-op in IDLE.
- FIFO:
  - Binary pointers of log2(DEPTH)+1 bits.
  - full = MSBs differ and the rest equal; empty = pointers equal.
  - Pointers wrap modulo 2*DEPTH.
  - Push and pop never occur in the same cycle: push only in ACQUIRE, pop only in DRAIN.
- Timestamp arithmetic: unsigned, TS_W bits; the subtraction is done in TS_W+1 bits and clamped at 0.
- Reset asserted mid-operation: immediate return to reset values; no partial record is emitted.

Decomposition:
- Shared package:
  - state enum {IDLE, CLEAR, ACQUIRE, DRAIN}.
  - record struct {amp[DATA_W], time[TS_W]}.
  - default constants WINDOW_DEF = 512, DET_LAT_DEF = 3.
- One sub-module: peak_rec_fifo, a synchronous single-clock FIFO with parameters DEPTH and WIDTH, ports push, pop, din, dout, full, empty, clr. It shares the clk/rst convention above.

Test Plan:
- Basic window: min_level_in = 100, start; peaks at counter 10 (amp 30) and 200 (amp 55); rec_ready = 1.
  - det_rst high for 1 cycle, then det_enable high for exactly 512 cycles.
  - Records (30, 7) then (55, 197); done pulses; pk_count = 2; det_min_level = 100.
- Overflow: 10 peaks at counters 20..29 with DEPTH = 8.
  - First 8 stored (ts 17..24), last 2 dropped; overflow = 1; pk_count = 10; exactly 8 records drained.
- Backpressure: 3 stored peaks; rec_ready held low 20 cycles, then toggled every other cycle.
  - rec_amp/rec_time stable while stalled; records emerge in order with no loss or duplication.
- Boundary timestamps and empty drain:
  - Peak at counter 1 gives ts 0 (clamped); peak at counter 511 (last cycle) is captured with ts 508.
  - A window with no peaks enters DRAIN empty and pulses done 1 cycle later.
- Abort and async reset:
  - abort at counter 100 with 2 stored peaks: IDLE next cycle, det_rst pulse, rec_valid never high, no done; a following start works normally.
  - rst asserted mid-DRAIN: outputs return to reset values without waiting for a clock edge.
